// File: rtl/lz_pkg.sv
// Constants shared by the leading-zero counter and its expander.
// Both ends use the same encoding for the all-zero operand.
package lz_pkg;

    localparam int LZ_WIDTH = 8;
    localparam int LZ_CNT_W = 4;
    // An all-zero operand is encoded as a count of LZ_MAX.
    localparam int LZ_MAX   = LZ_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/lz_expand_dp.sv
// Expander datapath: load/shift register, shift down-counter and saturation flag.
// The FSM in the top level drives the load and shift enables.
module lz_expand_dp
    import lz_pkg::*;
#(
    parameter int WIDTH = LZ_WIDTH,
    parameter int CNT_W = LZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [CNT_W-1:0] lz_i,
    input  logic [WIDTH-2:0] frac_i,
    output logic [WIDTH-1:0] shreg_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LZ_MAX);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (load_i) begin
            // Restore the implicit leading one; clamp oversized counts.
            shreg_d = {1'b1, frac_i};
            cnt_d   = (lz_i > CNT_MAX) ? CNT_MAX : lz_i;
            sat_d   = (lz_i > CNT_MAX);
        end else if (shift_i) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign shreg_o = shreg_q;
    assign cnt_o   = cnt_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/lz_expand_8.sv
// Rebuilds an 8-bit operand from its leading-zero code using a serial right
// shifter, with valid/ready handshakes on the input and output sides.
module lz_expand_8
    import lz_pkg::*;
#(
    parameter int WIDTH = LZ_WIDTH,
    parameter int CNT_W = LZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_lz,
    input  logic [WIDTH-2:0] in_frac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    logic [1:0]       state_q, state_d;
    logic             load, shift;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    // Gated by rst_n so no code is taken while reset is held.
    assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign load     = in_valid & in_ready;
    assign shift    = (state_q == ST_SHIFT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = (in_lz == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (load)           state_d = (in_lz == '0) ? ST_DONE : ST_SHIFT;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    lz_expand_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .lz_i    (in_lz),
        .frac_i  (in_frac),
        .shreg_o (shreg),
        .cnt_o   (cnt),
        .sat_o   (sat)
    );

    assign out_valid = (state_q == ST_DONE);
    assign out_data  = shreg;
    assign out_sat   = sat;

endmodule

// File: tb/tb_lz_expand_8.sv
// Directed-vector bench for lz_expand_8: table vectors, backpressure,
// reset mid-transaction and a full round trip through a leading-zero model.
module tb_lz_expand_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_lz = '0;
    logic [6:0] in_frac = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lz_expand_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lz     (in_lz),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    typedef struct {
        logic [3:0] lz;
        logic [6:0] frac;
        logic [7:0] exp_data;
        logic       exp_sat;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lz8(input logic [7:0] x);
        for (int i = 7; i >= 0; i--)
            if (x[i]) return 7 - i;
        return 8;
    endfunction

    // Waits (bounded) for in_ready, sampled on the falling edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // Presents one code, returns the number of rising edges after the accept
    // edge before out_valid is seen (-1 on timeout).
    task automatic send(input logic [3:0] lz, input logic [6:0] frac, output int lat);
        bit ok;
        wait_ready(ok);
        in_valid = 1'b1;
        in_lz    = lz;
        in_frac  = frac;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_lz   = 4'hF;
        in_frac = 7'h55;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int  lat;
        bit  ok;
        bit  seen;
        logic [7:0] x, sh;
        logic [6:0] fr;
        int  l;

        vecs[0] = '{4'd0,  7'b0101010, 8'hAA, 1'b0, 0};
        vecs[1] = '{4'd3,  7'b1100000, 8'h1C, 1'b0, 3};
        vecs[2] = '{4'd8,  7'h7F,      8'h00, 1'b0, 8};
        vecs[3] = '{4'd11, 7'h7F,      8'h00, 1'b1, 8};
        vecs[4] = '{4'd1,  7'h7F,      8'h7F, 1'b0, 1};
        vecs[5] = '{4'd7,  7'h00,      8'h01, 1'b0, 7};
        vecs[6] = '{4'd15, 7'h00,      8'h00, 1'b1, 8};
        vecs[7] = '{4'd4,  7'b1010101, 8'h0D, 1'b0, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst_n = 1'b1;
        #1 check("release_in_ready", in_ready, 1);

        // Table vectors, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].lz, vecs[i].frac, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_sat", i), out_sat, vecs[i].exp_sat);
        end
        @(negedge clk);
        check("idle_after_vecs", out_valid, 0);

        // Backpressure then back-to-back accept in DONE
        out_ready = 1'b0;
        send(4'd2, 7'h00, lat);
        check("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_data_hold", out_data, 8'h20);
            check("bp_valid_hold", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_lz     = 4'd0;
        in_frac   = 7'h01;
        #1 check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_data", out_data, 8'h81);
        check("b2b_sat", out_sat, 0);
        @(negedge clk);
        check("b2b_idle", out_valid, 0);

        // Reset in the middle of a long shift
        wait_ready(ok);
        in_valid = 1'b1;
        in_lz    = 4'd6;
        in_frac  = 7'h3C;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_sat", out_sat, 0);
        check("midrst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_release_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);

        // Round trip of every byte through the leading-zero encoding
        for (int v = 0; v < 256; v++) begin
            x  = 8'(v);
            l  = lz8(x);
            sh = 8'(x << l);
            fr = sh[6:0];
            wait_ready(ok);
            in_valid  = 1'b1;
            in_lz     = 4'(l);
            in_frac   = fr;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 in_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                check($sformatf("rt_timeout_%0d", v), 0, 1);
            end else begin
                check($sformatf("rt_data_%0d", v), out_data, x);
                check($sformatf("rt_sat_%0d", v), out_sat, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
